// File: rtl/multi_tick_divider.sv
// multi_tick_divider: NUM_CH independent, runtime-programmable clock-enable generators on sys_clk.
// Define SQUARE_OUT_EN to add a 50% duty square wave per channel on sq_out; otherwise sq_out is 0.
module multi_tick_divider #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DEF_DIV = 31250,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq_out
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("NUM_CH must be at least 1");
  end
  if (longint'(DEF_DIV) >= (longint'(1) << CNT_W)) begin : g_bad_def_div
    $error("DEF_DIV does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);

  // Terminal count for a divisor; a divisor of 0 behaves as 1.
  function automatic logic [CNT_W-1:0] last_count(input logic [CNT_W-1:0] div);
    return (div == '0) ? '0 : div - CNT_W'(1);
  endfunction

  logic [CNT_W-1:0]  count_q    [NUM_CH];
  logic [CNT_W-1:0]  count_d    [NUM_CH];
  logic [CNT_W-1:0]  div_act_q  [NUM_CH];
  logic [CNT_W-1:0]  div_act_d  [NUM_CH];
  logic [CNT_W-1:0]  div_pend_q [NUM_CH];
  logic [CNT_W-1:0]  div_pend_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] wrap, wr_acc;

  always_comb begin
    cfg_ready = 1'b1;
    wrap      = '0;
    wr_acc    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // ">=" also catches a count left above a freshly shrunk divisor.
      wrap[i]   = ch_en[i] && (count_q[i] >= last_count(div_act_q[i]));
      wr_acc[i] = cfg_valid && !pend_q[i] && (cfg_ch == CH_W'(i));
      if (cfg_ch == CH_W'(i)) cfg_ready = !pend_q[i];
    end
  end

  always_comb begin
    count_d    = count_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    tick_d     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync_restart) begin
        count_d[i] = '0;
        if (pend_q[i]) begin
          div_act_d[i] = div_pend_q[i];
          pend_d[i]    = 1'b0;
        end
      end else begin
        if (ch_en[i]) begin
          if (wrap[i]) begin
            count_d[i] = '0;
            tick_d[i]  = 1'b1;
          end else begin
            count_d[i] = count_q[i] + CNT_W'(1);
          end
        end
        // The wrap above already used the old divisor; the new one takes over afterwards.
        if (pend_q[i] && (wrap[i] || !ch_en[i])) begin
          div_act_d[i] = div_pend_q[i];
          pend_d[i]    = 1'b0;
        end
      end
      // A write can only land on a channel with nothing pending, so it never collides with an apply.
      if (wr_acc[i]) begin
        div_pend_d[i] = cfg_div;
        pend_d[i]     = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i]    <= '0;
        div_act_q[i]  <= DEF_DIV_W;
        div_pend_q[i] <= DEF_DIV_W;
      end
      pend_q <= '0;
      tick_q <= '0;
    end else begin
      count_q    <= count_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
    end
  end

  assign tick = tick_q;

`ifdef SQUARE_OUT_EN
  logic [NUM_CH-1:0] sq_q, sq_d;

  always_comb begin
    sq_d = sq_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync_restart) begin
        sq_d[i] = 1'b0;
      end else if (tick_d[i]) begin
        sq_d[i] = !sq_q[i];
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      sq_q <= '0;
    end else begin
      sq_q <= sq_d;
    end
  end

  assign sq_out = sq_q;
`else
  assign sq_out = '0;
`endif

endmodule

// File: tb/tb_multi_tick_divider.sv
// Directed bench for multi_tick_divider (NUM_CH=4, CNT_W=16, DEF_DIV=5) with immediate assertions.
module tb_multi_tick_divider;

  logic        sys_clk;
  logic        reset_n;
  logic [3:0]  ch_en;
  logic        sync_restart;
  logic        cfg_valid;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        cfg_ready;
  logic [3:0]  tick;
  logic [3:0]  sq_out;

  int errors = 0;
  int checks = 0;

  multi_tick_divider #(
    .NUM_CH (4),
    .CNT_W  (16),
    .DEF_DIV(5)
  ) dut (
    .sys_clk     (sys_clk),
    .reset_n     (reset_n),
    .ch_en       (ch_en),
    .sync_restart(sync_restart),
    .cfg_valid   (cfg_valid),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cfg_ready   (cfg_ready),
    .tick        (tick),
    .sq_out      (sq_out)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] sq_exp(input logic [3:0] v);
`ifdef SQUARE_OUT_EN
    return v;
`else
    return 4'b0000 & v;
`endif
  endfunction

  initial begin
    reset_n      = 1'b0;
    ch_en        = 4'b0000;
    sync_restart = 1'b0;
    cfg_valid    = 1'b0;
    cfg_ch       = 2'd0;
    cfg_div      = 16'd0;

    // Reset state
    step();
    step();
    chk("rst_tick", tick, 4'b0000);
    chk("rst_sq", sq_out, 4'b0000);
    chk("rst_ready", 4'(cfg_ready), 4'd1);

    // Channel 0 at default divisor 5
    reset_n = 1'b1;
    ch_en   = 4'b0001;
    for (int e = 1; e <= 15; e++) begin
      step();
      chk("def_tick", tick, (e % 5 == 0) ? 4'b0001 : 4'b0000);
    end

    // Channel 1: D=5 -> 3 written at count 2
    ch_en = 4'b0011;
    step();
    step();
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd3;
    #1;
    chk("wr3_ready_pre", 4'(cfg_ready), 4'd1);
    step();
    cfg_valid = 1'b0;
    chk("wr3_ready_c", 4'(cfg_ready), 4'd0);
    chk("wr3_tick_c", 4'(tick[1]), 4'd0);
    step();
    chk("wr3_ready_d", 4'(cfg_ready), 4'd0);
    chk("wr3_tick_d", 4'(tick[1]), 4'd0);
    step();
    chk("wr3_tick_wrap", 4'(tick[1]), 4'd1);
    chk("wr3_ready_wrap", 4'(cfg_ready), 4'd1);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("wr3_period", 4'(tick[1]), (k % 3 == 0) ? 4'd1 : 4'd0);
    end

    // Channel 2: divisor 0 applied while disabled, then divisor 1 while running
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd0;
    step();
    cfg_valid = 1'b0;
    chk("d0_ready_pend", 4'(cfg_ready), 4'd0);
    step();
    chk("d0_ready_applied", 4'(cfg_ready), 4'd1);
    chk("d0_tick_off", 4'(tick[2]), 4'd0);
    ch_en = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("d0_tick_cont", 4'(tick[2]), 4'd1);
    end
    cfg_valid = 1'b1; cfg_div = 16'd1;
    step();
    cfg_valid = 1'b0;
    chk("d1_ready_pend", 4'(cfg_ready), 4'd0);
    chk("d1_tick", 4'(tick[2]), 4'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("d1_ready", 4'(cfg_ready), 4'd1);
      chk("d1_tick_cont", 4'(tick[2]), 4'd1);
    end

    // Channel 2 back to D=5, then back-to-back writes with a ch3 write in the stall
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd5;
    step();
    cfg_valid = 1'b0;
    step();
    chk("bb_apply5_tick", 4'(tick[2]), 4'd1);
    cfg_valid = 1'b1; cfg_div = 16'd4;
    step();
    cfg_div = 16'd6;
    #1;
    chk("bb_stall_ready", 4'(cfg_ready), 4'd0);
    step();
    cfg_ch = 2'd3; cfg_div = 16'd7;
    #1;
    chk("bb_ch3_ready", 4'(cfg_ready), 4'd1);
    step();
    cfg_ch = 2'd2; cfg_div = 16'd6;
    #1;
    chk("bb_stall_ready2", 4'(cfg_ready), 4'd0);
    step();
    chk("bb_e4_ready", 4'(cfg_ready), 4'd0);
    chk("bb_e4_tick", 4'(tick[2]), 4'd0);
    step();
    chk("bb_e5_tick", 4'(tick[2]), 4'd1);
    chk("bb_e5_ready", 4'(cfg_ready), 4'd1);
    step();
    cfg_valid = 1'b0;
    chk("bb_e6_tick", 4'(tick[2]), 4'd0);
    chk("bb_e6_ready", 4'(cfg_ready), 4'd0);
    for (int k = 7; k <= 15; k++) begin
      step();
      chk("bb_period", 4'(tick[2]), (k == 9 || k == 15) ? 4'd1 : 4'd0);
    end

    // Channel 3: D=7 shrunk to 2 while disabled at count 5 -> forced wrap on resume
    ch_en = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("fw_run", 4'(tick[3]), 4'd0);
    end
    ch_en = 4'b0111;
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd2;
    step();
    cfg_valid = 1'b0;
    chk("fw_hold_tick", 4'(tick[3]), 4'd0);
    chk("fw_ready_pend", 4'(cfg_ready), 4'd0);
    step();
    chk("fw_ready_applied", 4'(cfg_ready), 4'd1);
    ch_en = 4'b1111;
    step();
    chk("fw_forced", 4'(tick[3]), 4'd1);
    step();
    chk("fw_after", 4'(tick[3]), 4'd0);
    step();
    chk("fw_period2", 4'(tick[3]), 4'd1);

    // sync_restart with every channel at D=5, mid-count
    cfg_valid = 1'b1; cfg_div = 16'd5;
    cfg_ch = 2'd1; step();
    cfg_ch = 2'd2; step();
    cfg_ch = 2'd3; step();
    cfg_valid = 1'b0;
    step();
    step();
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    chk("sync_tick", tick, 4'b0000);
    chk("sync_sq", sq_out, 4'b0000);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("sync_aligned", tick, (k % 5 == 0) ? 4'b1111 : 4'b0000);
    end

    // Channel 0 at D=4: square wave period 8
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd4;
    step();
    cfg_valid = 1'b0;
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    ch_en = 4'b0001;
    for (int e = 1; e <= 16; e++) begin
      step();
      chk("sq_tick", tick, (e % 4 == 0) ? 4'b0001 : 4'b0000);
      chk("sq_wave", sq_out, sq_exp(((e / 4) % 2 == 1) ? 4'b0001 : 4'b0000));
    end

    // Reset mid-run discards a pending write and restores DEF_DIV
    ch_en = 4'b0011;
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd9;
    step();
    cfg_valid = 1'b0;
    step();
    step();
    step();
    chk("pre_rst_tick", tick, 4'b0001);
    chk("pre_rst_sq", sq_out, sq_exp(4'b0001));
    chk("pre_rst_ready", 4'(cfg_ready), 4'd0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mid_rst_tick", tick, 4'b0000);
    chk("mid_rst_sq", sq_out, 4'b0000);
    chk("mid_rst_ready", 4'(cfg_ready), 4'd1);
    ch_en = 4'b0001;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("post_rst_tick", tick, (e == 5) ? 4'b0001 : 4'b0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
